fetch_unit: RTL

- Instruction-fetch stage directly upstream of the program ROM (PMEM_*).
- Generates the word-aligned fetch address `pc_read_c0` and captures the ROM's registered output `instr_reg_c1` one cycle later.
- Buffers instruction+PC pairs in a small FIFO and hands them to decode over a valid/ready handshake.
- Accepts a redirect (jump/branch/trap target) from execute that flushes all in-flight and buffered fetches.

---
 rtl/fetch_pkg.sv | 12 +
 rtl/fetch_fifo.sv | 58 +++++
 rtl/fetch_unit.sv | 97 +++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared constants and payload type for the instruction-fetch stage.
package fetch_pkg;
  localparam int          FETCH_PC_W     = 10;
  localparam int unsigned FETCH_RESET_PC = 0;
  localparam int          INSTR_W        = 32;
  localparam logic [INSTR_W-1:0] NOP     = 32'h0000_0013;

  typedef struct packed {
    logic [INSTR_W-1:0]    instr;
    logic [FETCH_PC_W-1:0] pc;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Small circular FIFO holding fetched {instr, pc} pairs; flush empties it in one cycle.
module fetch_fifo import fetch_pkg::*; #(
  parameter int  DEPTH = 3,
  parameter type T     = fetch_entry_t
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  T                           data_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output T                           head_o,
  output logic                       empty_o
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  T                mem_q [DEPTH];
  logic [AW-1:0]   rd_q, wr_q;
  logic [CW-1:0]   count_q;
  logic            do_push, do_pop;

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i & ~empty_o;
  // A push into a full FIFO is only accepted if the head leaves the same cycle.
  assign do_push = push_i & ((count_q != CW'(DEPTH)) | do_pop);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_q];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q   <= '{default: '0};
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= nxt(wr_q);
      end
      if (do_pop) rd_q <= nxt(rd_q);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: drives ROM address, captures the registered ROM word, buffers for decode.
// Optional FETCH_MISALIGN_CHK_EN adds fetch_fault and blocks misaligned redirects.
module fetch_unit import fetch_pkg::*; #(
  parameter int          PC_W     = FETCH_PC_W,
  parameter int unsigned RESET_PC = FETCH_RESET_PC,
  parameter int          DEPTH    = 3
) (
  input  logic               clk,
  input  logic               reset,
  output logic [PC_W-1:0]    pc_read_c0,
  input  logic [INSTR_W-1:0] instr_reg_c1,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    instr_pc
`ifdef FETCH_MISALIGN_CHK_EN
  ,
  output logic               fetch_fault
`endif
);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [PC_W-1:0] RST_PC = RESET_PC[PC_W-1:0];

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } entry_t;

  logic [PC_W-1:0] pc_q, pc_d, pc_c1_q, pc_c1_d;
  logic            inflight_q, inflight_d;
  logic            issue, room, push, pop, empty;
  logic [CW-1:0]   count;
  entry_t          head, wdata;

`ifdef FETCH_MISALIGN_CHK_EN
  logic fault_q, fault_d, misalign;
  assign misalign    = (redirect_pc[1:0] != 2'b00);
  assign fetch_fault = fault_q;
`endif

  // Credit is based on start-of-cycle occupancy; a same-cycle pop does not free a slot.
  assign room = (int'(count) + int'(inflight_q)) < DEPTH;

  always_comb begin
    pc_read_c0 = reset ? RST_PC : (redirect_valid ? redirect_pc : pc_q);
`ifdef FETCH_MISALIGN_CHK_EN
    issue   = redirect_valid ? ~misalign : (~fault_q & room);
    fault_d = redirect_valid ? misalign : fault_q;
`else
    issue   = redirect_valid | room;
`endif
    push       = inflight_q & ~redirect_valid;
    pc_d       = issue ? pc_read_c0 + PC_W'(4) : pc_q;
    pc_c1_d    = issue ? pc_read_c0 : pc_c1_q;
    inflight_d = issue;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q       <= RST_PC;
      pc_c1_q    <= '0;
      inflight_q <= 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
      fault_q    <= 1'b0;
`endif
    end else begin
      pc_q       <= pc_d;
      pc_c1_q    <= pc_c1_d;
      inflight_q <= inflight_d;
`ifdef FETCH_MISALIGN_CHK_EN
      fault_q    <= fault_d;
`endif
    end
  end

  assign wdata.instr = instr_reg_c1;
  assign wdata.pc    = pc_c1_q;
  assign pop         = instr_valid & instr_ready;

  fetch_fifo #(.DEPTH(DEPTH), .T(entry_t)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .data_i  (wdata),
    .pop_i   (pop),
    .flush_i (redirect_valid),
    .count_o (count),
    .head_o  (head),
    .empty_o (empty)
  );

  assign instr_valid = ~empty;
  assign instr       = head.instr;
  assign instr_pc    = head.pc;
endmodule
